// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample, result, coefficient and control signals of fir_serial_mac.
interface fir_serial_mac_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int AW     = 5
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;
  logic                     coef_wr;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     flush;
  logic                     busy;
  modport master (
    output in_data, in_valid, out_ready, coef_wr, coef_addr, coef_data, flush,
    input  in_ready, out_data, out_sat, out_valid, busy
  );
  modport slave (
    input  in_data, in_valid, out_ready, coef_wr, coef_addr, coef_data, flush,
    output in_ready, out_data, out_sat, out_valid, busy
  );
endinterface

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR filter, one shared MAC, loadable coefficients,
// round-half-up scaling and saturation, valid/ready on both sides.
module fir_serial_mac #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 21,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 7
) (
  input logic             clk_i,
  input logic             rst_ni,
  fir_serial_mac_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam int RW    = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'((64'(1) << OUT_SHIFT) >> 1);
  localparam logic signed [RW-1:0] HI   = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] LO   = ~HI;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] dl_q   [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic [AW-1:0]            wp_q, wp_d, rp_q, rp_d, k_q, k_d, wp_base;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_nx;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     sat_q, sat_d;
  logic signed [PW-1:0]     prod;
  logic signed [RW-1:0]     rnd;
  logic                     idle, accept, coef_ok, hi, lo;
  assign idle    = state_q == IDLE;
  assign accept  = idle && bus.in_valid;
  assign coef_ok = idle && bus.coef_wr && ({1'b0, bus.coef_addr} < (AW + 1)'(TAPS));
  assign wp_base = bus.flush ? '0 : wp_q;
  // rp_q walks backwards from the newest sample, so entry rp_q is x[n-k_q]
  assign prod    = dl_q[rp_q] * coef_q[k_q];
  assign acc_nx  = acc_q + ACC_W'(prod);
  assign rnd     = (RW'(acc_nx) + HALF) >>> OUT_SHIFT;
  assign hi      = rnd > HI;
  assign lo      = rnd < LO;
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        wp_d = wp_base;
        if (bus.in_valid) begin
          state_d = MAC;
          rp_d    = wp_base;
          wp_d    = wp_base == AW'(TAPS - 1) ? '0 : wp_base + 1'b1;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_nx;
        k_d   = k_q + 1'b1;
        rp_d  = rp_q == '0 ? AW'(TAPS - 1) : rp_q - 1'b1;
        if (k_q == AW'(TAPS - 1)) begin
          state_d = OUT;
          out_d   = hi ? HI[OUT_W-1:0] : lo ? LO[OUT_W-1:0] : rnd[OUT_W-1:0];
          sat_d   = hi | lo;
        end
      end
      OUT:     state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  // flush clears first; a sample accepted in the same cycle then lands at entry 0
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < TAPS; i++) begin
        dl_q[i]   <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (idle && bus.flush)
        for (int i = 0; i < TAPS; i++) dl_q[i] <= '0;
      if (accept) dl_q[wp_base] <= bus.in_data;
      if (coef_ok) coef_q[bus.coef_addr] <= bus.coef_data;
    end
  assign bus.in_ready  = idle;
  assign bus.busy      = !idle;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_data  = out_q;
  assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: three builds (16b/shift0, 8b/shift7, 8b/shift0) driven in lockstep
// from one directed vector table plus hand-written multi-cycle sequences.
module tb_fir_serial_mac;
  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [7:0] in_data = '0, coef_data = '0;
  logic in_valid = 1'b0, out_ready = 1'b0, coef_wr = 1'b0, flush = 1'b0;
  logic [4:0] coef_addr = '0;
  int n_tests = 0, n_fail = 0, lat, ya, yb, yc, sa, sb, sc;
  int C [21] = '{1, 3, 4, 3, -2, -7, -7, 2, 18, 34, 40, 34, 18, 2, -7, -7, -2, 3, 4, 3, 1};
  typedef struct {int x; bit fl; int sel; bit cy; int y; bit cs; int s;} vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  fir_serial_mac_if #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .AW(5)) ia ();
  fir_serial_mac_if #(.DATA_W(8), .COEF_W(8), .OUT_W(8),  .AW(5)) ib ();
  fir_serial_mac_if #(.DATA_W(8), .COEF_W(8), .OUT_W(8),  .AW(5)) ic ();
  fir_serial_mac #(.OUT_W(16), .OUT_SHIFT(0)) ua (.clk_i(clk), .rst_ni(rst_n), .bus(ia.slave));
  fir_serial_mac                              ub (.clk_i(clk), .rst_ni(rst_n), .bus(ib.slave));
  fir_serial_mac #(.OUT_W(8),  .OUT_SHIFT(0)) uc (.clk_i(clk), .rst_ni(rst_n), .bus(ic.slave));

  assign ia.in_data = in_data;     assign ib.in_data = in_data;     assign ic.in_data = in_data;
  assign ia.in_valid = in_valid;   assign ib.in_valid = in_valid;   assign ic.in_valid = in_valid;
  assign ia.out_ready = out_ready; assign ib.out_ready = out_ready; assign ic.out_ready = out_ready;
  assign ia.coef_wr = coef_wr;     assign ib.coef_wr = coef_wr;     assign ic.coef_wr = coef_wr;
  assign ia.coef_addr = coef_addr; assign ib.coef_addr = coef_addr; assign ic.coef_addr = coef_addr;
  assign ia.coef_data = coef_data; assign ib.coef_data = coef_data; assign ic.coef_data = coef_data;
  assign ia.flush = flush;         assign ib.flush = flush;         assign ic.flush = flush;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic void add(input int x, input bit fl, input int sel, input bit cy,
                              input int y, input bit cs, input int s);
    vec_t v;
    v = '{x: x, fl: fl, sel: sel, cy: cy, y: y, cs: cs, s: s};
    tbl.push_back(v);
  endfunction

  task automatic wr(input int addr, input int d);
    coef_wr = 1'b1;
    coef_addr = 5'(addr);
    coef_data = 8'(d);
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic send(input int x, input bit fl);
    in_data = 8'(x);
    in_valid = 1'b1;
    flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    coef_wr = 1'b0;
  endtask

  // lat counts the acceptance edge as edge 1
  task automatic wait_out(input bit mac_wr);
    lat = 1;
    coef_wr = mac_wr;
    while (!ia.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    coef_wr = 1'b0;
    if (!ia.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: out_valid 0 after %0d edges, expected 1", lat);
    end
    ya = int'(ia.out_data); yb = int'(ib.out_data); yc = int'(ic.out_data);
    sa = int'(ia.out_sat);  sb = int'(ib.out_sat);  sc = int'(ic.out_sat);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input int x, input bit fl, input bit mac_wr);
    send(x, fl);
    wait_out(mac_wr);
    ack();
  endtask

  initial begin
    int y, s;
    add(1, 1, 0, 1, C[0], 1, 0);
    for (int i = 1; i < 23; i++) add(0, 0, 0, 1, i < 21 ? C[i] : 0, 1, 0);
    for (int i = 0; i < 25; i++)
      add(100, i == 0, 1, i >= 20 || i == 0 || i == 6 || i == 9 || i == 13,
          i >= 20 ? 108 : i == 0 ? 1 : i == 6 ? -4 : i == 9 ? 38 : 112, 1, 0);
    for (int i = 0; i < 22; i++)
      add(127, i == 0, 2, i <= 1 || i >= 20, 127, i <= 1 || i >= 20, i == 0 ? 0 : 1);
    for (int i = 0; i < 22; i++)
      add(-128, i == 0, 2, i <= 1 || i >= 20, -128, i <= 1 || i >= 20, i == 0 ? 0 : 1);

    #2;
    check("rst_in_ready", int'(ia.in_ready), 1);
    check("rst_busy", int'(ib.busy), 0);
    check("rst_out_valid", int'(ic.out_valid), 0);
    check("rst_out_data", int'(ia.out_data), 0);
    check("rst_out_sat", int'(ib.out_sat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 21; k++) wr(k, C[k]);
    foreach (tbl[i]) begin
      run(tbl[i].x, tbl[i].fl, 1'b0);
      y = tbl[i].sel == 0 ? ya : tbl[i].sel == 1 ? yb : yc;
      s = tbl[i].sel == 0 ? sa : tbl[i].sel == 1 ? sb : sc;
      if (tbl[i].cy) check($sformatf("vec%0d_y", i), y, tbl[i].y);
      if (tbl[i].cs) check($sformatf("vec%0d_sat", i), s, tbl[i].s);
    end

    // output stall: next sample held on the input until the handshake frees the block
    in_data = 8'sd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_data = 8'sd0;
    wait_out(1'b0);
    check("latency", lat, 22);
    check("stall_first", ya, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_data", i), int'(ia.out_data), 1);
      check($sformatf("stall%0d_in_ready", i), int'(ia.in_ready), 0);
      check($sformatf("stall%0d_valid", i), int'(ia.out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_busy", int'(ia.busy), 0);
    check("release_in_ready", int'(ia.in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accepted", int'(ia.busy), 1);
    wait_out(1'b0);
    check("next_out", ya, 3);
    ack();

    // coefficient-write boundaries and flush+sample in one cycle
    for (int k = 0; k < 21; k++) wr(k, k == 0 ? 1 : k == 1 ? 2 : 0);
    wr(21, 99);
    coef_addr = 5'd1; coef_data = 8'sd50;
    run(5, 1'b1, 1'b1);
    check("flush_s0", ya, 5);
    run(0, 1'b0, 1'b0);
    check("mac_wr_ignored", ya, 10);
    run(0, 1'b0, 1'b0);
    check("flush_s2", ya, 0);
    check("addr21_ignored_c", yc, 0);
    coef_wr = 1'b1; coef_addr = 5'd0; coef_data = 8'sd3;
    run(5, 1'b1, 1'b0);
    check("same_cycle_coef", ya, 15);
    run(0, 1'b0, 1'b0);
    check("same_cycle_next", ya, 10);

    // asynchronous reset in the middle of MAC
    send(7, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_data", int'(ia.out_data), 0);
    check("arst_busy", int'(ia.busy), 0);
    check("arst_in_ready", int'(ia.in_ready), 1);
    check("arst_out_valid", int'(ia.out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 check("abandoned_no_out", int'(ia.out_valid), 0);
    run(1, 1'b0, 1'b0);
    check("zero_coef0", ya, 0);
    run(0, 1'b0, 1'b0);
    check("zero_coef1", ya, 0);
    run(0, 1'b0, 1'b0);
    check("zero_coef2", yb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
